// File: rtl/mem_block_pkg.sv
// Shared types and primitive geometry for the initialisable weight/activation memory.
package mem_block_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        CONST = 2'd1,
        RAMP  = 2'd2
    } init_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } mem_state_e;

    localparam int PRIM_DEPTH = 1024;
    localparam int PRIM_AW    = 10;
    localparam int PRIM_W     = 8;

endpackage

// File: rtl/dpram_1024x8.sv
// Simple dual-port 1024x8 RAM: one write port, one registered read port, read-before-write.
module dpram_1024x8 (
    input  logic       clk,
    input  logic       we,
    input  logic [9:0] waddr,
    input  logic [7:0] wdata,
    input  logic [9:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:1023];
    logic [7:0] rdata_q;

    // Non-blocking write and read on the same edge give old data on an address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_byte_lane.sv
// One byte lane of the wide memory: adapts the block's address width to the primitive.
module mem_byte_lane
    import mem_block_pkg::*;
#(
    parameter int ADDRW = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDRW-1:0]  waddr,
    input  logic [PRIM_W-1:0] wdata,
    input  logic [ADDRW-1:0]  raddr,
    output logic [PRIM_W-1:0] rdata
);

    logic [PRIM_AW-1:0] waddr_ext;
    logic [PRIM_AW-1:0] raddr_ext;

    assign waddr_ext = PRIM_AW'(waddr);
    assign raddr_ext = PRIM_AW'(raddr);

    dpram_1024x8 u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr_ext),
        .wdata (wdata),
        .raddr (raddr_ext),
        .rdata (rdata)
    );

endmodule

// File: rtl/init_memory_block.sv
// Wide byte-lane RAM with a built-in fill sequencer, byte-enabled writes and read-valid tracking.
module init_memory_block
    import mem_block_pkg::*;
#(
    parameter int               DATAW      = 128,
    parameter int               DEPTH      = 64,
    parameter int               ADDRW      = $clog2(DEPTH),
    parameter int               INIT_MODE  = 0,
    parameter logic [DATAW-1:0] INIT_VALUE = {DATAW/8{8'h01}},
    parameter int               OUT_REG    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_req,
    output logic               init_busy,
    output logic               init_done,
    input  logic               wen,
    input  logic [ADDRW-1:0]   waddr,
    input  logic [DATAW-1:0]   wdata,
    input  logic [DATAW/8-1:0] wbe,
    output logic               wr_drop,
    input  logic               ren,
    input  logic [ADDRW-1:0]   raddr,
    output logic               rvalid,
    output logic [DATAW-1:0]   rdata
);

    localparam int               LANES     = DATAW / PRIM_W;
    localparam bit               FILL_EN   = (INIT_MODE != int'(NONE));
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

    mem_state_e         state_q, state_d;
    logic [ADDRW-1:0]   fill_cnt_q, fill_cnt_d;
    logic               init_done_q, init_done_d;
    logic               wr_drop_q, wr_drop_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATAW-1:0]   hold_q, hold_d;

    logic               fill_active;
    logic               user_wr;
    logic [PRIM_W-1:0]  ramp_byte;
    logic [DATAW-1:0]   fill_word;
    logic [LANES-1:0]   lane_we;
    logic [DATAW-1:0]   lane_wdata;
    logic [ADDRW-1:0]   lane_addr;
    logic [DATAW-1:0]   ram_rdata;
    logic               out_valid;
    logic [DATAW-1:0]   out_data;

    assign fill_active = (state_q == FILL);
    assign user_wr     = (state_q == READY) && wen;
    assign ramp_byte   = PRIM_W'(fill_cnt_q);

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            IDLE: begin
                fill_cnt_d = '0;
                if (FILL_EN) begin
                    state_d = FILL;
                end else begin
                    state_d     = READY;
                    init_done_d = 1'b1;
                end
            end
            FILL: begin
                fill_cnt_d = fill_cnt_q + ADDRW'(1);
                if (fill_cnt_q == LAST_ADDR) begin
                    state_d     = READY;
                    fill_cnt_d  = '0;
                    init_done_d = 1'b1;
                end
            end
            READY: begin
                if (init_req && FILL_EN) begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The fill sequencer owns every lane while active; user writes are only steered in READY.
    always_comb begin
        fill_word  = (INIT_MODE == int'(RAMP)) ? {LANES{ramp_byte}} : INIT_VALUE;
        lane_we    = '0;
        lane_wdata = wdata;
        lane_addr  = waddr;
        if (fill_active) begin
            lane_we    = '1;
            lane_wdata = fill_word;
            lane_addr  = fill_cnt_q;
        end else if (user_wr) begin
            lane_we = wbe;
        end
    end

    always_comb begin
        wr_drop_d  = fill_active && wen && (|wbe);
        rd_valid_d = (state_q == READY) && ren;
        hold_d     = rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            init_done_q <= 1'b0;
            wr_drop_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            init_done_q <= init_done_d;
            wr_drop_q   <= wr_drop_d;
            rd_valid_q  <= rd_valid_d;
            hold_q      <= hold_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mem_byte_lane #(.ADDRW(ADDRW)) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .waddr (lane_addr),
            .wdata (lane_wdata[g*PRIM_W +: PRIM_W]),
            .raddr (raddr),
            .rdata (ram_rdata[g*PRIM_W +: PRIM_W])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic             oreg_valid_q, oreg_valid_d;
        logic [DATAW-1:0] oreg_data_q, oreg_data_d;

        always_comb begin
            oreg_valid_d = rd_valid_q;
            oreg_data_d  = rd_valid_q ? ram_rdata : oreg_data_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                oreg_valid_q <= 1'b0;
                oreg_data_q  <= '0;
            end else begin
                oreg_valid_q <= oreg_valid_d;
                oreg_data_q  <= oreg_data_d;
            end
        end

        assign out_valid = oreg_valid_q;
        assign out_data  = oreg_data_q;
    end else begin : g_no_out_reg
        assign out_valid = rd_valid_q;
        assign out_data  = ram_rdata;
    end

    // The RAM port re-reads every cycle, so the hold register masks it outside valid cycles.
    assign rvalid    = out_valid;
    assign rdata     = out_valid ? out_data : hold_q;
    assign init_busy = fill_active;
    assign init_done = init_done_q;
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_init_memory_block.sv
// Directed bench: constant-fill instance (DEPTH 64) and ramp-fill instance with output register (DEPTH 300).
module tb_init_memory_block;

    localparam logic [127:0] ONES   = {16{8'h01}};
    localparam logic [127:0] BE_VAL = {{14{8'h01}}, 16'hFFFF};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int na, nb, guard;

    logic         a_rst_n, a_init_req, a_init_busy, a_init_done;
    logic         a_wen, a_wr_drop, a_ren, a_rvalid;
    logic [5:0]   a_waddr, a_raddr;
    logic [127:0] a_wdata, a_rdata;
    logic [15:0]  a_wbe;

    logic         b_rst_n, b_init_req, b_init_busy, b_init_done;
    logic         b_wen, b_wr_drop, b_ren, b_rvalid;
    logic [8:0]   b_waddr, b_raddr;
    logic [127:0] b_wdata, b_rdata;
    logic [15:0]  b_wbe;

    init_memory_block #(
        .DATAW(128), .DEPTH(64), .INIT_MODE(1), .OUT_REG(0)
    ) dut_a (
        .clk(clk), .rst_n(a_rst_n), .init_req(a_init_req),
        .init_busy(a_init_busy), .init_done(a_init_done),
        .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata), .wbe(a_wbe),
        .wr_drop(a_wr_drop), .ren(a_ren), .raddr(a_raddr),
        .rvalid(a_rvalid), .rdata(a_rdata)
    );

    init_memory_block #(
        .DATAW(128), .DEPTH(300), .INIT_MODE(2), .OUT_REG(1)
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .init_req(b_init_req),
        .init_busy(b_init_busy), .init_done(b_init_done),
        .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .wbe(b_wbe),
        .wr_drop(b_wr_drop), .ren(b_ren), .raddr(b_raddr),
        .rvalid(b_rvalid), .rdata(b_rdata)
    );

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic readA(input logic [5:0] addr);
        a_ren   = 1'b1;
        a_raddr = addr;
        applyStimulus(1);
        a_ren   = 1'b0;
    endtask

    initial begin
        logic [5:0] addrs [3];
        addrs = '{6'd0, 6'd31, 6'd63};

        a_rst_n = 0; a_init_req = 0; a_wen = 0; a_waddr = 0; a_wdata = 0; a_wbe = 0;
        a_ren = 0; a_raddr = 0;
        b_rst_n = 0; b_init_req = 0; b_wen = 0; b_waddr = 0; b_wdata = 0; b_wbe = 0;
        b_ren = 0; b_raddr = 0;
        applyStimulus(2);
        checkOutput("rst_busy", 128'(a_init_busy), 128'd0);
        checkOutput("rst_done", 128'(a_init_done), 128'd0);
        checkOutput("rst_rvalid", 128'(a_rvalid), 128'd0);
        checkOutput("rst_rdata", a_rdata, 128'd0);

        a_rst_n = 1; b_rst_n = 1;
        applyStimulus(1);
        na = 0; nb = 0; guard = 0;
        while ((a_init_busy || b_init_busy) && guard < 1000) begin
            if (a_init_busy) na++;
            if (b_init_busy) nb++;
            guard++;
            applyStimulus(1);
        end
        checkOutput("const_busy_len", 128'(na), 128'd64);
        checkOutput("ramp_busy_len", 128'(nb), 128'd300);
        checkOutput("const_done", 128'(a_init_done), 128'd1);
        checkOutput("ramp_done", 128'(b_init_done), 128'd1);

        for (int i = 0; i < 3; i++) begin
            readA(addrs[i]);
            checkOutput("const_rvalid", 128'(a_rvalid), 128'd1);
            checkOutput("const_rdata", a_rdata, ONES);
        end

        a_wen = 1; a_waddr = 6'd10; a_wdata = '1; a_wbe = 16'h0003;
        applyStimulus(1);
        a_wen = 0;
        readA(6'd10);
        checkOutput("be_rdata", a_rdata, BE_VAL);
        a_raddr = 6'd0;
        applyStimulus(2);
        checkOutput("hold_rvalid", 128'(a_rvalid), 128'd0);
        checkOutput("hold_rdata", a_rdata, BE_VAL);

        a_wen = 1; a_waddr = 6'd11; a_wdata = '1; a_wbe = 16'h0000;
        applyStimulus(1);
        a_wen = 0;
        checkOutput("wbe0_no_drop", 128'(a_wr_drop), 128'd0);
        readA(6'd11);
        checkOutput("wbe0_rdata", a_rdata, ONES);

        a_wen = 1; a_waddr = 6'd12; a_wdata = {16{8'hAA}}; a_wbe = '1;
        a_ren = 1; a_raddr = 6'd12;
        applyStimulus(1);
        a_wen = 0; a_ren = 0;
        checkOutput("rbw_rvalid", 128'(a_rvalid), 128'd1);
        checkOutput("rbw_old", a_rdata, ONES);
        readA(6'd12);
        checkOutput("rbw_new", a_rdata, {16{8'hAA}});

        a_init_req = 1;
        applyStimulus(1);
        a_init_req = 0;
        a_wen = 1; a_waddr = 6'd10; a_wdata = {16{8'h55}}; a_wbe = '1;
        a_ren = 1; a_raddr = 6'd0;
        na = 0;
        while (a_init_busy && na < 200) begin
            na++;
            applyStimulus(1);
            a_wen = 0; a_ren = 0;
            if (na == 1) begin
                checkOutput("drop_pulse", 128'(a_wr_drop), 128'd1);
                checkOutput("fill_no_rvalid", 128'(a_rvalid), 128'd0);
            end else if (na == 2) begin
                checkOutput("drop_single", 128'(a_wr_drop), 128'd0);
            end
        end
        checkOutput("refill_busy_len", 128'(na), 128'd64);
        checkOutput("refill_done", 128'(a_init_done), 128'd1);
        readA(6'd10);
        checkOutput("refill_rdata", a_rdata, ONES);

        a_init_req = 1;
        applyStimulus(1);
        a_init_req = 0;
        applyStimulus(20);
        a_rst_n = 0;
        applyStimulus(2);
        checkOutput("midrst_busy", 128'(a_init_busy), 128'd0);
        checkOutput("midrst_done", 128'(a_init_done), 128'd0);
        checkOutput("midrst_rdata", a_rdata, 128'd0);
        a_rst_n = 1;
        applyStimulus(1);
        na = 0;
        while (a_init_busy && na < 200) begin
            na++;
            applyStimulus(1);
        end
        checkOutput("midrst_busy_len", 128'(na), 128'd64);
        readA(6'd40);
        checkOutput("midrst_rdata_after", a_rdata, ONES);

        b_ren = 1; b_raddr = 9'd5;
        applyStimulus(1);
        checkOutput("oreg_t1_rvalid", 128'(b_rvalid), 128'd0);
        b_raddr = 9'd6;
        applyStimulus(1);
        b_ren = 0;
        checkOutput("oreg_t2_rvalid", 128'(b_rvalid), 128'd1);
        checkOutput("ramp_addr5", b_rdata, {16{8'h05}});
        applyStimulus(1);
        checkOutput("b2b_rvalid", 128'(b_rvalid), 128'd1);
        checkOutput("ramp_addr6", b_rdata, {16{8'h06}});
        applyStimulus(1);
        checkOutput("oreg_idle_rvalid", 128'(b_rvalid), 128'd0);
        checkOutput("oreg_hold", b_rdata, {16{8'h06}});

        b_ren = 1; b_raddr = 9'd259;
        applyStimulus(1);
        b_raddr = 9'd299;
        applyStimulus(1);
        b_ren = 0;
        checkOutput("ramp_addr259", b_rdata, {16{8'h03}});
        applyStimulus(1);
        checkOutput("ramp_addr299", b_rdata, {16{8'h2B}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
